// File: rtl/booth_pkg.sv
// Shared radix-4 Booth definitions: digit encoding, triplet decode and
// the partial-product count / index-width helpers.
package booth_pkg;

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} digit_e;

  function automatic int npp(input int width);
    return width / 2 + 1;
  endfunction

  function automatic int idxw(input int width);
    return $clog2(width / 2 + 1);
  endfunction

  // Triplet is {B[2i+1], B[2i], B[2i-1]}.
  function automatic digit_e decode(input logic [2:0] triplet);
    case (triplet)
      3'b001, 3'b010: return POS1;
      3'b011:         return POS2;
      3'b100:         return NEG2;
      3'b101, 3'b110: return NEG1;
      default:        return ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_sel.sv
// Combinational Booth selector: turns a digit and multiplicand A into a
// one's-complement partial product plus its +1 correction bit.
module booth_sel
  import booth_pkg::*;
#(
  parameter int WIDTH = 14
) (
  input  digit_e                   digit,
  input  logic        [WIDTH-1:0]  a,
  output logic signed [WIDTH+1:0]  pp_data,
  output logic                     pp_neg
);

  always_comb begin
    pp_data = '0;
    pp_neg  = 1'b0;
    case (digit)
      POS1: pp_data = {2'b00, a};
      POS2: pp_data = {1'b0, a, 1'b0};
      NEG1: begin
        pp_data = ~{2'b00, a};
        pp_neg  = 1'b1;
      end
      NEG2: begin
        pp_data = ~{1'b0, a, 1'b0};
        pp_neg  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/booth_pp_seq.sv
// Sequential radix-4 Booth partial-product generator, one digit per beat.
// Define BOOTH_PP_ACC_EN to add the on-block accumulator and prod_* ports.
module booth_pp_seq
  import booth_pkg::*;
#(
  parameter  int WIDTH = 14,
  localparam int NPP   = npp(WIDTH),
  localparam int IDXW  = idxw(WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic        [WIDTH-1:0]   in_a,
  input  logic        [WIDTH-1:0]   in_b,
  output logic                      pp_valid,
  input  logic                      pp_ready,
  output logic signed [WIDTH+1:0]   pp_data,
  output logic                      pp_neg,
  output logic        [IDXW-1:0]    pp_idx,
  output logic                      pp_last
`ifdef BOOTH_PP_ACC_EN
  ,
  output logic                      prod_valid,
  output logic        [2*WIDTH-1:0] prod_data
`endif
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state;
  logic [WIDTH-1:0] a_p0, b_p0;
  logic [IDXW-1:0]  idx_p0;
  logic [WIDTH+2:0] b_ext;
  logic [2:0]       triplet;
  digit_e           digit;
  logic             in_fire, pp_fire;

  // B[-1] = 0 on the right, zero bits above the MSB on the left.
  assign b_ext    = {2'b00, b_p0, 1'b0};
  assign triplet  = 3'(b_ext >> {idx_p0, 1'b0});
  assign digit    = (state == RUN) ? decode(triplet) : ZERO;

  assign pp_valid = (state == RUN);
  assign pp_idx   = pp_valid ? idx_p0 : '0;
  assign pp_last  = pp_valid && (idx_p0 == IDXW'(NPP - 1));
  assign in_ready = (state == IDLE) || (pp_last && pp_ready);
  assign in_fire  = in_valid && in_ready;
  assign pp_fire  = pp_valid && pp_ready;

  booth_sel #(.WIDTH(WIDTH)) u_sel (
    .digit   (digit),
    .a       (a_p0),
    .pp_data (pp_data),
    .pp_neg  (pp_neg)
  );

  // Operand capture and digit sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_p0   <= '0;
      b_p0   <= '0;
      idx_p0 <= '0;
    end else if (in_fire) begin
      state  <= RUN;
      a_p0   <= in_a;
      b_p0   <= in_b;
      idx_p0 <= '0;
    end else if (pp_fire) begin
      if (pp_last) begin
        state  <= IDLE;
        idx_p0 <= '0;
      end else begin
        idx_p0 <= idx_p0 + IDXW'(1);
      end
    end
  end

`ifdef BOOTH_PP_ACC_EN
  localparam int ACCW = 2 * WIDTH + 2;

  logic signed [ACCW-1:0] acc_p1, term, acc_nxt;

  always_comb begin
    term    = (ACCW'(pp_data) + ACCW'(pp_neg)) <<< {idx_p0, 1'b0};
    acc_nxt = acc_p1 + term;
  end

  // Accumulation; the final beat's sum goes straight to prod_data so a
  // back-to-back operand can clear the accumulator in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p1     <= '0;
      prod_valid <= 1'b0;
      prod_data  <= '0;
    end else begin
      prod_valid <= pp_fire && pp_last;
      if (pp_fire && pp_last) prod_data <= acc_nxt[2*WIDTH-1:0];
      if (in_fire)      acc_p1 <= '0;
      else if (pp_fire) acc_p1 <= acc_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_booth_pp_seq.sv
// Scoreboard bench for booth_pp_seq (WIDTH=14); prod_* checks follow BOOTH_PP_ACC_EN.
module tb_booth_pp_seq;

  localparam int W   = 14;
  localparam int PW  = W + 2;
  localparam int NPP = 8;

  typedef struct {
    logic [PW-1:0]  data;
    logic           neg;
    logic [2:0]     idx;
    logic           last;
    logic [2*W-1:0] prod;
  } beat_t;

  logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, pp_ready = 1'b1;
  logic [W-1:0]  in_a = '0, in_b = '0;
  logic          in_ready, pp_valid, pp_neg, pp_last;
  logic [PW-1:0] pp_data;
  logic [2:0]    pp_idx;
`ifdef BOOTH_PP_ACC_EN
  logic           prod_valid;
  logic [2*W-1:0] prod_data;
  logic [2*W-1:0] prodq[$];
`endif

  int     n_chk = 0, n_err = 0;
  int     rdy_mode = 0;
  beat_t  q[$];
  longint sum = 0;
  logic   prev_stall = 1'b0;
  logic [PW-1:0] h_data;
  logic          h_neg, h_last;
  logic [2:0]    h_idx;

  always #5 clk = ~clk;

  booth_pp_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .pp_valid   (pp_valid),
    .pp_ready   (pp_ready),
    .pp_data    (pp_data),
    .pp_neg     (pp_neg),
    .pp_idx     (pp_idx),
    .pp_last    (pp_last)
`ifdef BOOTH_PP_ACC_EN
    ,
    .prod_valid (prod_valid),
    .prod_data  (prod_data)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference digits from the arithmetic value d = -2*b2 + b1 + b0.
  task automatic push_op(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W+2:0] be;
    beat_t e;
    be = {2'b00, b, 1'b0};
    for (int i = 0; i < NPP; i++) begin
      int d, mag;
      d   = int'(be[2*i+1]) + int'(be[2*i]) - 2 * int'(be[2*i+2]);
      mag = (d < 0 ? -d : d) * int'(a);
      e.data = (d < 0) ? PW'(~mag) : PW'(mag);
      e.neg  = (d < 0);
      e.idx  = 3'(i);
      e.last = (i == NPP - 1);
      e.prod = (2*W)'(a) * (2*W)'(b);
      q.push_back(e);
    end
`ifdef BOOTH_PP_ACC_EN
    prodq.push_back((2*W)'(a) * (2*W)'(b));
`endif
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int waited = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (in_ready || waited > 100) break;
      waited++;
    end
    check("accept", in_ready, 1);
    if (in_ready) push_op(a, b);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = W'($urandom);
    in_b = W'($urandom);
    check("first_valid", pp_valid, 1);
    check("first_idx", pp_idx, 0);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || pp_valid) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain", q.size(), 0);
`ifdef BOOTH_PP_ACC_EN
    check("prod_drain", prodq.size(), 0);
`endif
  endtask

  task automatic wait_idx(input int want);
    int n = 0;
    while (!(pp_valid && pp_idx == 3'(want)) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_idx", pp_idx, want);
  endtask

  initial forever begin
    @(posedge clk); #2;
    case (rdy_mode)
      0:       pp_ready = 1'b1;
      1:       pp_ready = 1'($urandom_range(0, 1));
      default: pp_ready = 1'b0;
    endcase
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      q.delete();
`ifdef BOOTH_PP_ACC_EN
      prodq.delete();
`endif
      sum = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_data", pp_data, h_data);
        check("hold_neg", pp_neg, h_neg);
        check("hold_idx", pp_idx, h_idx);
        check("hold_last", pp_last, h_last);
      end
      if (!pp_valid) begin
        check("idle_zero", {pp_data, pp_neg, pp_idx, pp_last}, 0);
      end else if (pp_ready) begin
        if (q.size() == 0) begin
          check("pp_spurious", pp_valid, 0);
        end else begin
          beat_t e;
          e = q.pop_front();
          check("pp_data", pp_data, e.data);
          check("pp_neg", pp_neg, e.neg);
          check("pp_idx", pp_idx, e.idx);
          check("pp_last", pp_last, e.last);
          sum += (longint'($signed(pp_data)) + longint'(pp_neg)) <<< (2 * int'(pp_idx));
          if (e.last) begin
            check("pp_sum", sum, e.prod);
            sum = 0;
          end
        end
      end
      prev_stall = pp_valid && !pp_ready;
      h_data = pp_data; h_neg = pp_neg; h_idx = pp_idx; h_last = pp_last;
`ifdef BOOTH_PP_ACC_EN
      if (prod_valid) begin
        if (prodq.size() == 0) check("prod_spurious", prod_valid, 0);
        else check("prod_data", prod_data, prodq.pop_front());
      end
`endif
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_pp_valid", pp_valid, 0);
    check("rst_pp_data", pp_data, 0);
    check("rst_pp_neg", pp_neg, 0);
    check("rst_pp_idx", pp_idx, 0);
    check("rst_pp_last", pp_last, 0);
`ifdef BOOTH_PP_ACC_EN
    check("rst_prod_valid", prod_valid, 0);
    check("rst_prod_data", prod_data, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(14'h0005, 14'h0003);
    drain();
    send(14'h3FFF, 14'h3FFF);
    drain();
    send(14'h2ABC, 14'h0000);
    drain();

    send(14'h1234, 14'h2F0F);
    wait_idx(2);
    rdy_mode = 2;
    repeat (3) @(posedge clk);
    #1;
    rdy_mode = 0;
    drain();

    send(14'h1111, 14'h2222);
    wait_idx(7);
    send(14'h0ABC, 14'h3A5A);
    drain();

    send(14'h3333, 14'h1357);
    wait_idx(4);
    rst_n = 1'b0;
    #1;
    check("midrst_pp_valid", pp_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_pp_last", pp_last, 0);
`ifdef BOOTH_PP_ACC_EN
    check("midrst_prod_valid", prod_valid, 0);
`endif
    @(posedge clk); #1;
`ifdef BOOTH_PP_ACC_EN
    check("midrst_prod_valid2", prod_valid, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_pp_valid", pp_valid, 0);
    send(14'h1ABC, 14'h0777);
    drain();

    rdy_mode = 1;
    for (int k = 0; k < 20; k++) send(W'($urandom), W'($urandom));
    rdy_mode = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/booth_pp_seq.md
BOOTH_PP_SEQ -- requirements
Module: booth_pp_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports are clk and rst_n.
REQ-002 Parameter WIDTH, default 14: unsigned operand width; even, at least 4; derived NPP = WIDTH/2+1, IDXW = clog2(NPP).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 in_valid  in  1  operand pair offered.
REQ-006 in_ready  out  1  block accepts the operand pair.
REQ-007 in_a  in  WIDTH  multiplicand A (unsigned).
REQ-008 in_b  in  WIDTH  multiplier B (unsigned).
REQ-009 pp_valid  out  1  partial product present.
REQ-010 pp_ready  in  1  consumer accepts the partial product.
REQ-011 pp_data  out  WIDTH+2  signed two's-complement partial product, one's-complemented when negative.
REQ-012 pp_neg  out  1  +1 correction for pp_data, at the same weight.
REQ-013 pp_idx  out  IDXW  digit index i; pp_data and pp_neg weight is 4^i.
REQ-014 pp_last  out  1  asserted with pp_idx == NPP-1.
REQ-015 prod_valid  out  1  one-cycle product pulse (BOOTH_PP_ACC_EN only).
REQ-016 prod_data  out  2*WIDTH  A*B (BOOTH_PP_ACC_EN only).

Function
REQ-017 Digit i SHALL use bits {B[2i+1],B[2i],B[2i-1]}, with B[-1]=0 and bits at or above WIDTH equal to 0.
REQ-018 Digit decode SHALL be: 000/111 gives 0, 001/010 gives +A, 011 gives +2A, 100 gives -2A, and 101/110 gives -A.
REQ-019 pp_data SHALL be {00,A} for +A, {0,A,0} for +2A, the bitwise inverse of the positive form for a negative digit with pp_neg=1, and all zero with pp_neg=0 for a zero digit.
REQ-020 The sum over i of (signed pp_data + pp_neg)·4^i SHALL equal A*B exactly.
REQ-021 The FSM SHALL have two states, IDLE and RUN.
REQ-022 In IDLE, in_ready=1; an in_valid&in_ready handshake latches A and B, sets idx=0, and moves the FSM to RUN.
REQ-023 In RUN, pp_valid=1; each pp_valid&pp_ready handshake increments idx.
REQ-024 A handshake while pp_last=1 SHALL return the FSM to IDLE, unless a new operand is accepted in the same cycle (REQ-027).
REQ-025 The first pp_valid SHALL occur in the cycle after input acceptance, and one partial product is issued per accepted beat.
REQ-026 While pp_valid=1 and pp_ready=0, pp_data, pp_neg, pp_idx and pp_last SHALL hold stable.
REQ-027 in_ready SHALL be 1 in IDLE, or in RUN when pp_last&pp_ready; a simultaneous input accept SHALL restart RUN at idx 0 with no bubble.
REQ-028 While pp_valid=0, pp_data, pp_neg, pp_idx and pp_last SHALL all be 0.
REQ-029 in_a and in_b SHALL be sampled only on the input handshake; later changes on them have no effect.

Reset
REQ-030 During reset, state SHALL be IDLE, all registers 0, and in_ready=1 with every other output 0.
REQ-031 An assertion of rst_n mid-operation SHALL abandon the operation with no pp_last or prod_valid.

Configuration
REQ-032 With BOOTH_PP_ACC_EN defined, the block SHALL include a (2*WIDTH+2)-bit accumulator, cleared on input acceptance.
REQ-033 With BOOTH_PP_ACC_EN defined, each accepted beat SHALL add (sext(pp_data)+pp_neg)<<2i to the accumulator.
REQ-034 With BOOTH_PP_ACC_EN defined, prod_valid SHALL pulse for one cycle after the pp_last handshake; prod_data = acc[2*WIDTH-1:0] and holds until the next product.
REQ-035 Without BOOTH_PP_ACC_EN, the prod_* ports and the accumulator SHALL be absent, and the remaining behaviour is identical.

Structure
REQ-036 Shared package booth_pkg SHALL hold the digit enum (ZERO, POS1, POS2, NEG1, NEG2) and the NPP/IDXW functions.
REQ-037 One combinational sub-module, booth_sel, SHALL map the digit and A to pp_data and pp_neg; the FSM, index and accumulator live in booth_pp_seq.

Verification (WIDTH=14, NPP=8, pp_data 16 bits)
REQ-038 A=0x0005, B=0x0003, pp_ready=1 -> idx0 0xFFFA/neg1, idx1 0x0005/neg0, idx2..7 0x0000/neg0; pp_last at idx7; prod_data=0x0000000F.
REQ-039 A=B=0x3FFF -> 8 beats, prod_data=0x0FFF8001; check the REQ-020 sum.
REQ-040 B=0x0000, A=0x2ABC -> 8 zero beats with pp_neg=0; prod_data=0.
REQ-041 pp_ready low for 3 cycles at idx2 -> pp_data and pp_idx stable throughout, and 8 beats total.
REQ-042 New in_valid held during the idx7 handshake -> accepted that cycle, next cycle pp_idx=0 with the new operands and no bubble.
REQ-043 rst_n low at idx4 -> the next cycle shows pp_valid=0, in_ready=1 and no prod_valid; a following operation is correct.
